mem_port_arbiter: RTL and testbench

- Shares one port of the 1024x16 dual-port block RAM between two requesters, for example the CPU datapath and a test/DMA engine.
- Each requester issues read, write, or read-modify-write-add transactions. The block serializes them with round-robin arbitration and sequences the RAM's one-cycle synchronous read latency.
- RMW is performed atomically on the port: read, add, write back.

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester channels and the shared RAM port of mem_port_arbiter.
// slave is the arbiter side; master is the requesters plus the RAM.
interface mem_port_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 16
);
   logic          req0, req1;
   logic [1:0]    op0, op1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1;
   logic          done0, done1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_q;
   logic          busy;

   modport slave (
      input  req0, op0, addr0, wdata0, req1, op1, addr1, wdata1, mem_q,
      output gnt0, done0, rdata0, gnt1, done1, rdata1,
             mem_we, mem_addr, mem_data, busy
   );

   modport master (
      output req0, op0, addr0, wdata0, req1, op1, addr1, wdata1, mem_q,
      input  gnt0, done0, rdata0, gnt1, done1, rdata1,
             mem_we, mem_addr, mem_data, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM port between two requesters,
// supporting read, write and atomic read-add-write transactions.
module mem_port_arbiter #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);
   localparam logic [1:0] OP_WR = 2'b01;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

   state_t        state, state_nxt;
   logic          owner, last_owner, winner, any_req;
   logic [1:0]    op_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r, rdata0_r, rdata1_r, operand, sum;

   assign any_req = bus.req0 | bus.req1;
   // On a tie the requester that did not own the last grant wins.
   assign winner  = (bus.req0 & bus.req1) ? ~last_owner : bus.req1;
   assign operand = op_r[0] ? DW'(addr_r) : wdata_r;
   assign sum     = bus.mem_q + operand;

   assign bus.rdata0 = rdata0_r;
   assign bus.rdata1 = rdata1_r;
   assign bus.busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= 1'b0;
         last_owner <= 1'b1;
         op_r       <= '0;
         addr_r     <= '0;
         wdata_r    <= '0;
         rdata0_r   <= '0;
         rdata1_r   <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            owner      <= winner;
            last_owner <= winner;
            op_r       <= winner ? bus.op1    : bus.op0;
            addr_r     <= winner ? bus.addr1  : bus.addr0;
            wdata_r    <= winner ? bus.wdata1 : bus.wdata0;
         end
         if (state == CAPTURE) begin
            if (owner) rdata1_r <= bus.mem_q;
            else       rdata0_r <= bus.mem_q;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.gnt0     = 1'b0;
      bus.gnt1     = 1'b0;
      bus.done0    = 1'b0;
      bus.done1    = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_data = '0;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = ACCESS;
         end
         ACCESS: begin
            bus.gnt0     = ~owner;
            bus.gnt1     = owner;
            bus.mem_addr = addr_r;
            if (op_r == OP_WR) begin
               bus.mem_we   = 1'b1;
               bus.mem_data = wdata_r;
               state_nxt    = DONE;
            end else begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            bus.mem_addr = addr_r;
            // RMW writes back in the same cycle the old word arrives on mem_q.
            if (op_r[1]) begin
               bus.mem_we   = 1'b1;
               bus.mem_data = sum;
            end
            state_nxt = DONE;
         end
         DONE: begin
            bus.done0 = ~owner;
            bus.done1 = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read RAM.
module tb_mem_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 16;
   localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_ADDW = 2'b10, OP_ADDA = 2'b11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
      bus.mem_q <= ram[bus.mem_addr];
   end

   typedef struct {
      logic          rq;
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_w;
      logic [DW-1:0] exp_rd;
   } txn_t;

   txn_t          vec [14];
   logic [DW-1:0] exp_rd [2];
   int            checks   = 0;
   int            failures = 0;

   function automatic txn_t mk(input logic rq, input logic [1:0] op, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_w,
                               input logic [DW-1:0] rd);
      txn_t t;
      t.rq = rq; t.op = op; t.addr = addr; t.wdata = wdata; t.exp_w = exp_w; t.exp_rd = rd;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic gnt_of(input logic rq);
      return rq ? bus.gnt1 : bus.gnt0;
   endfunction
   function automatic logic done_of(input logic rq);
      return rq ? bus.done1 : bus.done0;
   endfunction
   function automatic logic [DW-1:0] rdata_of(input logic rq);
      return rq ? bus.rdata1 : bus.rdata0;
   endfunction

   task automatic drive(input logic rq, input logic r, input logic [1:0] op,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (rq) begin
         bus.req1 = r; bus.op1 = op; bus.addr1 = addr; bus.wdata1 = wdata;
      end else begin
         bus.req0 = r; bus.op0 = op; bus.addr0 = addr; bus.wdata0 = wdata;
      end
   endtask

   // Called at a negedge with the FSM idle; returns at the negedge after it is idle again.
   task automatic run_txn(input txn_t v, input int idx);
      int   n;
      logic is_wr;
      is_wr = (v.op == OP_WR);
      drive(v.rq, 1'b1, v.op, v.addr, v.wdata);
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt_of(v.rq) && n < 8);
      check($sformatf("v%0d gnt_latency", idx), n, 1);
      check($sformatf("v%0d other_gnt", idx), gnt_of(~v.rq), 0);
      check($sformatf("v%0d acc_addr", idx), bus.mem_addr, v.addr);
      check($sformatf("v%0d acc_we", idx), bus.mem_we, is_wr);
      if (is_wr) check($sformatf("v%0d acc_data", idx), bus.mem_data, v.wdata);
      drive(v.rq, 1'b0, OP_RD, '0, '0);
      if (!is_wr) begin
         @(negedge clk);
         check($sformatf("v%0d cap_done_early", idx), done_of(v.rq), 0);
         check($sformatf("v%0d cap_addr", idx), bus.mem_addr, v.addr);
         check($sformatf("v%0d cap_we", idx), bus.mem_we, v.op[1]);
         if (v.op[1]) check($sformatf("v%0d cap_data", idx), bus.mem_data, v.exp_w);
         exp_rd[v.rq] = v.exp_rd;
      end
      @(negedge clk);
      check($sformatf("v%0d done", idx), done_of(v.rq), 1);
      check($sformatf("v%0d done_we", idx), bus.mem_we, 0);
      check($sformatf("v%0d rdata", idx), rdata_of(v.rq), exp_rd[v.rq]);
      check($sformatf("v%0d other_rdata", idx), rdata_of(~v.rq), exp_rd[~v.rq]);
      @(negedge clk);
      check($sformatf("v%0d idle_busy", idx), bus.busy, 0);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.rdata0, bus.rdata1,
                   bus.mem_we, bus.mem_addr, bus.mem_data, bus.busy} == '0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ng, low_run, done_n;
      vec[0]  = mk(1'b0, OP_WR,   10'h005, 16'h1234, 16'h1234, 16'h0000);
      vec[1]  = mk(1'b0, OP_RD,   10'h005, 16'h0000, 16'h0000, 16'h1234);
      vec[2]  = mk(1'b1, OP_WR,   10'h1FF, 16'h0010, 16'h0010, 16'h0000);
      vec[3]  = mk(1'b1, OP_ADDA, 10'h1FF, 16'h0000, 16'h020F, 16'h0010);
      vec[4]  = mk(1'b1, OP_RD,   10'h1FF, 16'h0000, 16'h0000, 16'h020F);
      vec[5]  = mk(1'b0, OP_WR,   10'h3FF, 16'hFFFF, 16'hFFFF, 16'h0000);
      vec[6]  = mk(1'b0, OP_ADDW, 10'h3FF, 16'h0002, 16'h0001, 16'hFFFF);
      vec[7]  = mk(1'b0, OP_RD,   10'h3FF, 16'h0000, 16'h0000, 16'h0001);
      vec[8]  = mk(1'b1, OP_ADDA, 10'h3FF, 16'h0000, 16'h0400, 16'h0001);
      vec[9]  = mk(1'b1, OP_RD,   10'h3FF, 16'h0000, 16'h0000, 16'h0400);
      vec[10] = mk(1'b0, OP_WR,   10'h000, 16'hABCD, 16'hABCD, 16'h0000);
      vec[11] = mk(1'b0, OP_ADDA, 10'h000, 16'h5555, 16'hABCD, 16'hABCD);
      vec[12] = mk(1'b1, OP_RD,   10'h000, 16'h0000, 16'h0000, 16'hABCD);
      vec[13] = mk(1'b0, OP_WR,   10'h200, 16'h0007, 16'h0007, 16'h0000);
      exp_rd[0] = '0;
      exp_rd[1] = '0;

      rst = 1'b0;
      drive(1'b0, 1'b0, OP_RD, '0, '0);
      drive(1'b1, 1'b0, OP_RD, '0, '0);
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      rst = 1'b1;

      for (int i = 0; i < 14; i++) run_txn(vec[i], i);

      // Both requesters reading continuously after reset: strict alternation.
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b1, OP_RD, 10'h005, '0);
      drive(1'b1, 1'b1, OP_RD, 10'h3FF, '0);
      ng = 0; low_run = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check("rr_gnt_exclusive", bus.gnt0 & bus.gnt1, 0);
         if (bus.gnt0 | bus.gnt1) begin
            check($sformatf("rr_gnt_order%0d", ng), bus.gnt1, ng % 2);
            ng++;
         end
         if (!bus.busy) low_run++;
         else if (low_run > 0) begin
            check("rr_idle_gap", low_run, 1);
            low_run = 0;
         end
      end
      check("rr_grant_count", ng, 4);
      drive(1'b0, 1'b0, OP_RD, '0, '0);
      drive(1'b1, 1'b0, OP_RD, '0, '0);
      n = 0;
      do begin @(negedge clk); n++; end while (bus.busy && n < 8);
      check("rr_back_idle", bus.busy, 0);
      check("rr_rdata0", bus.rdata0, 16'h1234);
      check("rr_rdata1", bus.rdata1, 16'h0400);

      // Reset in the CAPTURE cycle of an RMW aborts the write-back.
      drive(1'b0, 1'b1, OP_ADDW, 10'h200, 16'h0001);
      @(negedge clk);
      check("abort_gnt0", bus.gnt0, 1);
      drive(1'b0, 1'b0, OP_RD, '0, '0);
      @(negedge clk);
      check("abort_cap_we", bus.mem_we, 1);
      #1 rst = 1'b0;
      #1;
      check("abort_we_drop", bus.mem_we, 0);
      check_all_zero("abort_outputs");
      @(negedge clk);
      rst = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      drive(1'b0, 1'b1, OP_RD, 10'h200, '0);
      drive(1'b1, 1'b1, OP_RD, 10'h1FF, '0);
      @(negedge clk);
      check("post_reset_gnt0", bus.gnt0, 1);
      check("post_reset_gnt1", bus.gnt1, 0);
      drive(1'b0, 1'b0, OP_RD, '0, '0);
      drive(1'b1, 1'b0, OP_RD, '0, '0);
      repeat (2) @(negedge clk);
      check("post_reset_done0", bus.done0, 1);
      check("post_reset_ram200", bus.rdata0, 16'h0007);
      @(negedge clk);
      exp_rd[0] = 16'h0007;

      // req1 alone, then a tie goes to req0; write takes 3 cycles, read 4.
      run_txn(mk(1'b1, OP_WR, 10'h010, 16'h1111, 16'h1111, 16'h0000), 100);
      drive(1'b0, 1'b1, OP_WR, 10'h011, 16'h2222);
      drive(1'b1, 1'b1, OP_RD, 10'h010, '0);
      @(negedge clk);
      check("tie_gnt0", bus.gnt0, 1);
      check("tie_gnt1", bus.gnt1, 0);
      drive(1'b0, 1'b0, OP_RD, '0, '0);
      n = 1;
      do begin @(negedge clk); n++; end while (bus.busy && n < 10);
      check("write_cycles", n, 3);
      @(negedge clk);
      check("held_req1_gnt", bus.gnt1, 1);
      drive(1'b1, 1'b0, OP_RD, '0, '0);
      n = 1; done_n = 0;
      do begin
         @(negedge clk); n++;
         if (bus.done1) done_n = n;
      end while (bus.busy && n < 10);
      check("read_cycles", n, 4);
      check("read_done_cycle", done_n, 3);
      check("read_rdata1", bus.rdata1, 16'h1111);
      check("read_rdata0_held", bus.rdata0, 16'h0007);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
